// File: rtl/taxi_fare_calc.sv
// taxi_fare_calc: trip accounting stage of the taximeter.
// Counts per-metre wheel pulses and produces a BCD fare using a base fare that
// covers a base distance, followed by a fixed BCD increment per step distance.
// Day and night increments are selected by a tariff bit latched at trip start.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, stop       single-cycle trip control pulses
//   meter_pulse       one pulse per metre travelled
//   night             tariff select, sampled when a trip starts
//   mode_btn          toggles the fare/distance display select
//   one..sibman       fare BCD digits 10^0..10^5
//   one_meter..baek_meter  distance BCD digits
//   bus               display select (1 = fare, 0 = distance)
//   busy              trip in progress (BASE or RUN)
module taxi_fare_calc #(
  parameter logic [23:0] BASE_FARE  = 24'h003800,
  parameter int unsigned BASE_DIST  = 100,
  parameter int unsigned STEP_DIST  = 10,
  parameter logic [23:0] STEP_FARE  = 24'h000100,
  parameter logic [23:0] NIGHT_FARE = 24'h000120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       meter_pulse,
  input  logic       night,
  input  logic       mode_btn,
  output logic [3:0] one,
  output logic [3:0] ten,
  output logic [3:0] baek,
  output logic [3:0] cheon,
  output logic [3:0] man,
  output logic [3:0] sibman,
  output logic [3:0] one_meter,
  output logic [3:0] ten_meter,
  output logic [3:0] baek_meter,
  output logic       bus,
  output logic       busy
);

  localparam int unsigned MAXD = (BASE_DIST > STEP_DIST) ? BASE_DIST : STEP_DIST;
  localparam int unsigned CW   = $clog2(MAXD + 1);
  localparam logic [CW-1:0] BASE_CNT = CW'(BASE_DIST);
  localparam logic [CW-1:0] STEP_CNT = CW'(STEP_DIST);

  typedef enum logic [1:0] {S_IDLE, S_BASE, S_RUN, S_HOLD} state_e;

  state_e        state_q, state_d;
  logic [23:0]   fare_q, fare_d;
  logic [11:0]   dist_q, dist_d;
  logic [CW-1:0] step_q, step_d;
  logic          night_q, night_d;
  logic          bus_q, bus_d;
  logic          busy_q, busy_d;

  logic [CW-1:0] step_inc;
  logic [24:0]   fare_sum;
  logic [23:0]   fare_step;

  // 6-digit BCD add; bit 24 of the result is the carry out of the top digit.
  function automatic logic [24:0] bcd_add6(input logic [23:0] a, input logic [23:0] b);
    logic        c;
    logic [4:0]  s;
    logic [23:0] r;
    c = 1'b0;
    r = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  // 3-digit BCD increment, holding at 999.
  function automatic logic [11:0] bcd_inc3(input logic [11:0] d);
    logic        c;
    logic [11:0] r;
    r = d;
    c = 1'b1;
    if (d != 12'h999) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (c) begin
          if (d[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = d[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign step_inc  = step_q + CW'(1);
  assign fare_sum  = bcd_add6(fare_q, night_q ? NIGHT_FARE : STEP_FARE);
  assign fare_step = fare_sum[24] ? 24'h999999 : fare_sum[23:0];

  always_comb begin
    state_d = state_q;
    fare_d  = fare_q;
    dist_d  = dist_q;
    step_d  = step_q;
    night_d = night_q;
    bus_d   = bus_q ^ mode_btn;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BASE;
          fare_d  = BASE_FARE;
          dist_d  = '0;
          step_d  = '0;
          night_d = night;
        end
      end
      S_BASE, S_RUN: begin
        // A pulse arriving with stop is still counted before entering HOLD.
        if (meter_pulse) begin
          dist_d = bcd_inc3(dist_q);
          if (state_q == S_BASE) begin
            if (step_inc == BASE_CNT) begin
              state_d = S_RUN;
              step_d  = '0;
            end else begin
              step_d = step_inc;
            end
          end else begin
            if (step_inc == STEP_CNT) begin
              fare_d = fare_step;
              step_d = '0;
            end else begin
              step_d = step_inc;
            end
          end
        end
        if (stop) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (start) begin
          state_d = S_BASE;
          fare_d  = BASE_FARE;
          dist_d  = '0;
          step_d  = '0;
          night_d = night;
        end else if (stop) begin
          state_d = S_IDLE;
          fare_d  = '0;
          dist_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_BASE) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fare_q  <= '0;
      dist_q  <= '0;
      step_q  <= '0;
      night_q <= 1'b0;
      bus_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fare_q  <= fare_d;
      dist_q  <= dist_d;
      step_q  <= step_d;
      night_q <= night_d;
      bus_q   <= bus_d;
      busy_q  <= busy_d;
    end
  end

  assign one        = fare_q[3:0];
  assign ten        = fare_q[7:4];
  assign baek       = fare_q[11:8];
  assign cheon      = fare_q[15:12];
  assign man        = fare_q[19:16];
  assign sibman     = fare_q[23:20];
  assign one_meter  = dist_q[3:0];
  assign ten_meter  = dist_q[7:4];
  assign baek_meter = dist_q[11:8];
  assign bus        = bus_q;
  assign busy       = busy_q;

endmodule
